// File: rtl/range_pkg.sv
// rtl/range_pkg.sv - shared count width, RAM geometry defaults and reader state encoding
package range_pkg;

   localparam int COUNT_W           = 16;
   localparam int DEF_RAM_WORDS     = 16;
   localparam int DEF_RAM_ADDR_BITS = 4;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WAIT_FILL = 3'd1,
      ADDR      = 3'd2,
      CAPTURE   = 3'd3,
      OUT       = 3'd4,
      DONE      = 3'd5
   } state_t;

endpackage

// File: rtl/range_reader_if.sv
// rtl/range_reader_if.sv - (index, count) output stream with valid/ready handshake
interface range_reader_if
   import range_pkg::*;
#(
   parameter int ADDR_W = DEF_RAM_ADDR_BITS
);

   logic              out_valid;
   logic              out_ready;
   logic [ADDR_W-1:0] out_index;
   logic [COUNT_W-1:0] out_count;

   modport master (
      output out_valid,
      output out_index,
      output out_count,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_index,
      input  out_count,
      output out_ready
   );

endinterface

// File: rtl/range_reader.sv
// rtl/range_reader.sv - walks the range count RAM, streams every word, tracks max (RANGE_READER_SUM_EN adds a running sum)
module range_reader
   import range_pkg::*;
#(
   parameter int RAM_WORDS     = DEF_RAM_WORDS,
   parameter int RAM_ADDR_BITS = DEF_RAM_ADDR_BITS
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              fill_done,
   input  logic                              scan_go,
   output logic [RAM_ADDR_BITS-1:0]          rd_addr,
   input  logic [COUNT_W-1:0]                rd_data,
   range_reader_if.master                    out_if,
   output logic [COUNT_W-1:0]                max_count,
   output logic [RAM_ADDR_BITS-1:0]          max_index,
   output logic                              busy,
   output logic                              scan_done,
   output logic                              abort,
   output logic [COUNT_W+RAM_ADDR_BITS-1:0]  sum_count
);

   localparam int SUM_W = COUNT_W + RAM_ADDR_BITS;
   localparam logic [RAM_ADDR_BITS-1:0] LAST_IDX = RAM_ADDR_BITS'(RAM_WORDS - 1);

   state_t                   state;
   logic [RAM_ADDR_BITS-1:0] idx;
   logic                     out_valid_q;
   logic [RAM_ADDR_BITS-1:0] out_index_q;
   logic [COUNT_W-1:0]       out_count_q;

   assign out_if.out_valid = out_valid_q;
   assign out_if.out_index = out_index_q;
   assign out_if.out_count = out_count_q;

   // rd_addr is loaded on entry to ADDR so the RAM samples it at the ADDR->CAPTURE edge
   // and the word is on rd_data while CAPTURE is active.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         idx         <= '0;
         rd_addr     <= '0;
         out_valid_q <= 1'b0;
         out_index_q <= '0;
         out_count_q <= '0;
         max_count   <= '0;
         max_index   <= '0;
         busy        <= 1'b0;
         scan_done   <= 1'b0;
         abort       <= 1'b0;
      end else begin
         abort <= 1'b0;
         if (!fill_done && (state inside {ADDR, CAPTURE, OUT})) begin
            // range restarted underneath us: RAM contents are stale
            abort       <= 1'b1;
            out_valid_q <= 1'b0;
            busy        <= 1'b0;
            state       <= IDLE;
         end else begin
            case (state)
               IDLE: begin
                  if (scan_go) begin
                     idx       <= '0;
                     max_count <= '0;
                     max_index <= '0;
                     busy      <= 1'b1;
                     scan_done <= 1'b0;
                     if (fill_done) begin
                        rd_addr <= '0;
                        state   <= ADDR;
                     end else begin
                        state <= WAIT_FILL;
                     end
                  end
               end
               WAIT_FILL: begin
                  if (fill_done) begin
                     rd_addr <= idx;
                     state   <= ADDR;
                  end
               end
               ADDR: state <= CAPTURE;
               CAPTURE: begin
                  out_count_q <= rd_data;
                  out_index_q <= idx;
                  out_valid_q <= 1'b1;
                  if (rd_data > max_count) begin
                     max_count <= rd_data;
                     max_index <= idx;
                  end
                  state <= OUT;
               end
               OUT: begin
                  if (out_valid_q && out_if.out_ready) begin
                     out_valid_q <= 1'b0;
                     if (idx == LAST_IDX) begin
                        state <= DONE;
                     end else begin
                        idx     <= idx + 1'b1;
                        rd_addr <= idx + 1'b1;
                        state   <= ADDR;
                     end
                  end
               end
               DONE: begin
                  busy      <= 1'b0;
                  scan_done <= 1'b1;
                  state     <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

`ifdef RANGE_READER_SUM_EN
   logic [SUM_W-1:0] sum_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q <= '0;
      end else if (state == IDLE && scan_go) begin
         sum_q <= '0;
      end else if (state == CAPTURE && fill_done) begin
         sum_q <= sum_q + SUM_W'(rd_data);
      end
   end

   assign sum_count = sum_q;
`else
   assign sum_count = '0;
`endif

endmodule

// File: tb/tb_range_reader.sv
// tb/tb_range_reader.sv - scoreboard bench for range_reader against a 1-cycle-latency RAM model
`timescale 1ns/1ps
module tb_range_reader;
   import range_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        fill_done = 1'b0;
   logic        scan_go = 1'b0;
   logic [3:0]  rd_addr;
   logic [15:0] rd_data = '0;
   logic [15:0] max_count;
   logic [3:0]  max_index;
   logic        busy, scan_done, abort;
   logic [19:0] sum_count;

   range_reader_if #(.ADDR_W(4)) out_if ();

   range_reader dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .fill_done (fill_done),
      .scan_go   (scan_go),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .out_if    (out_if.master),
      .max_count (max_count),
      .max_index (max_index),
      .busy      (busy),
      .scan_done (scan_done),
      .abort     (abort),
      .sum_count (sum_count)
   );

   always #5 clk = ~clk;

   logic [15:0] ram [16];
   always @(posedge clk) rd_data <= ram[rd_addr];

   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // ready driver applies after the #1 stimulus slot so tests can change ready_fix cleanly
   logic rnd_en = 1'b0;
   logic ready_fix = 1'b1;
   always @(posedge clk) begin
      #2;
      out_if.out_ready = rnd_en ? 1'($urandom_range(0, 1)) : ready_fix;
   end
   initial out_if.out_ready = 1'b1;

   logic [19:0] exp_q[$];
   logic        stall_q = 1'b0;
   logic [3:0]  held_idx = '0;
   logic [15:0] held_cnt = '0;

   always @(negedge clk) begin
      logic [19:0] e;
      if (rst_n && !abort) begin
         if (stall_q) begin
            check("hold_valid", out_if.out_valid, 1);
            check("hold_idx", out_if.out_index, held_idx);
            check("hold_cnt", out_if.out_count, held_cnt);
         end
         if (out_if.out_valid && out_if.out_ready) begin
            if (exp_q.size() == 0) begin
               check("sb_extra", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("sb_idx", out_if.out_index, e[19:16]);
               check("sb_cnt", out_if.out_count, e[15:0]);
            end
         end
      end
      stall_q  = rst_n && out_if.out_valid && !out_if.out_ready;
      held_idx = out_if.out_index;
      held_cnt = out_if.out_count;
   end

   function automatic logic [19:0] collatz_sum();
      logic [19:0] s = '0;
      for (int i = 0; i < 16; i++) s += 20'(ram[i]);
      return s;
   endfunction

   task automatic load_collatz();
      logic [15:0] c [16] = '{0, 1, 7, 2, 5, 8, 16, 3, 19, 6, 14, 9, 9, 17, 17, 4};
      for (int i = 0; i < 16; i++) ram[i] = c[i];
   endtask

   task automatic start_scan();
      for (int i = 0; i < 16; i++) exp_q.push_back({4'(i), ram[i]});
      scan_go = 1'b1;
      @(posedge clk); #1;
      scan_go = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int cycles);
      cycles = 0;
      while (!scan_done && cycles < budget) begin
         @(posedge clk); #1;
         cycles++;
      end
      if (!scan_done) check("done_timeout", scan_done, 1);
   endtask

   function automatic logic [19:0] exp_sum(input logic [19:0] s);
`ifdef RANGE_READER_SUM_EN
      return s;
`else
      return 20'(s & 20'h0);
`endif
   endfunction

   initial begin
      int cyc;
      load_collatz();
      #3;
      check("rst_valid", out_if.out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", scan_done, 0);
      check("rst_abort", abort, 0);
      check("rst_max", max_count, 0);
      check("rst_addr", rd_addr, 0);
      check("rst_sum", sum_count, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      fill_done = 1'b1;
      @(posedge clk); #1;

      // nominal Collatz scan
      start_scan();
      check("busy_run", busy, 1);
      wait_done(200, cyc);
      check("latency", cyc, 49);
      check("max_count", max_count, 19);
      check("max_index", max_index, 8);
      check("sum", sum_count, exp_sum(20'd137));
      check("busy_end", busy, 0);
      check("sb_left", exp_q.size(), 0);

      // back-pressure
      rnd_en = 1'b1;
      start_scan();
      wait_done(2000, cyc);
      rnd_en = 1'b0;
      ready_fix = 1'b1;
      check("bp_max", max_count, 19);
      check("bp_maxi", max_index, 8);
      check("bp_left", exp_q.size(), 0);

      // scan requested before fill completes
      fill_done = 1'b0;
      check("addr_pre", rd_addr, 15);
      start_scan();
      for (int i = 0; i < 10; i++) begin
         check("wait_busy", busy, 1);
         @(posedge clk); #1;
      end
      fill_done = 1'b1;
      @(posedge clk); #1;
      check("wf_addr", rd_addr, 0);
      check("wf_busy", busy, 1);
      wait_done(200, cyc);
      check("wf_left", exp_q.size(), 0);
      check("wf_max", max_count, 19);

      // all-equal words keep the lowest index
      for (int i = 0; i < 16; i++) ram[i] = 16'd5;
      start_scan();
      wait_done(200, cyc);
      check("tie_max", max_count, 5);
      check("tie_idx", max_index, 0);
      check("tie_sum", sum_count, exp_sum(collatz_sum()));
      check("tie_left", exp_q.size(), 0);

      // abort during word 6
      load_collatz();
      start_scan();
      cyc = 0;
      while (!(out_if.out_valid && out_if.out_index == 4'd6) && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("ab_reach", out_if.out_index, 6);
      ready_fix = 1'b0;
      fill_done = 1'b0;
      @(posedge clk); #1;
      check("ab_pulse", abort, 1);
      check("ab_valid", out_if.out_valid, 0);
      check("ab_busy", busy, 0);
      check("ab_done", scan_done, 0);
      check("ab_max", max_count, 16);
      check("ab_maxi", max_index, 6);
      check("ab_popped", exp_q.size(), 10);
      exp_q.delete();
      @(posedge clk); #1;
      check("ab_once", abort, 0);
      fill_done = 1'b1;
      ready_fix = 1'b1;
      @(posedge clk); #1;
      start_scan();
      wait_done(200, cyc);
      check("ab_relat", cyc, 49);
      check("ab_remax", max_count, 19);
      check("ab_left", exp_q.size(), 0);

      // asynchronous reset mid-OUT
      ready_fix = 1'b0;
      start_scan();
      cyc = 0;
      while (!out_if.out_valid && cyc < 50) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("rs_valid_pre", out_if.out_valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("rs_valid", out_if.out_valid, 0);
      check("rs_busy", busy, 0);
      check("rs_idx", out_if.out_index, 0);
      check("rs_max", max_count, 0);
      check("rs_addr", rd_addr, 0);
      exp_q.delete();
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      ready_fix = 1'b1;
      @(posedge clk); #1;
      start_scan();
      wait_done(200, cyc);
      check("rs_lat", cyc, 49);
      check("rs_max2", max_count, 19);
      check("rs_maxi2", max_index, 8);
      check("rs_sum2", sum_count, exp_sum(20'd137));
      check("rs_left", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=1 exp=0");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/range_reader.md
Name: range_reader

Overview:
- Reader end of the range count RAM. Once the range block's fill completes, it walks every RAM address through the range read port (start[RAM_ADDR_BITS-1:0] in, count out, 1-cycle read latency).
- Streams each (index, count) pair out over a valid/ready handshake.
- Tracks the maximum count and its index for the display/host side of the lab1 top level.

Parameters:
- RAM_WORDS, 16, number of count words to read (must match range).
- RAM_ADDR_BITS, 4, address width (must match range).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- fill_done  input  1  range "done"; high while RAM holds a complete fill
- scan_go  input  1  single-cycle request to start a scan
- rd_addr  output  RAM_ADDR_BITS  read address to range start[RAM_ADDR_BITS-1:0]; top zero-extends to 32 bits
- rd_data  input  16  range "count"; valid the cycle after rd_addr is presented
- out_valid  output  1  out_index/out_count hold a word
- out_ready  input  1  consumer accepts the word
- out_index  output  RAM_ADDR_BITS  address of streamed word
- out_count  output  16  streamed count
- max_count  output  16  largest count seen this scan
- max_index  output  RAM_ADDR_BITS  address of max_count
- busy  output  1  scan in progress
- scan_done  output  1  high from scan completion until next accepted scan_go
- abort  output  1  one-cycle pulse when a scan is abandoned
- sum_count  output  16+RAM_ADDR_BITS  sum of all counts (see Optional Feature)

Behaviour:
- Reset is asynchronous and active-low. Every output and register is 0 in reset; state = IDLE.
- States and transitions:
  - IDLE: on scan_go, clear idx, max_count, max_index and sum; busy<=1; scan_done<=0. Go to ADDR if fill_done, else WAIT_FILL.
  - WAIT_FILL: stay until fill_done=1, then go to ADDR.
  - ADDR: rd_addr=idx (registered, so it is stable at the RAM through CAPTURE). Next state CAPTURE.
  - CAPTURE: latch rd_data into out_count and idx into out_index; out_valid<=1. If rd_data > max_count (strictly), update max_count and max_index; ties keep the lower index. Next state OUT.
  - OUT: hold out_valid and the data stable until out_valid&&out_ready. On that handshake: out_valid<=0. If idx==RAM_WORDS-1, go to DONE; otherwise idx<=idx+1 and go to ADDR.
  - DONE: busy<=0, scan_done<=1, go to IDLE. scan_done stays high in IDLE.
- Throughput is 1 word per 3 cycles with out_ready tied high. Scan latency from scan_go to scan_done is 3*RAM_WORDS+1 cycles; 49 for the defaults.
- scan_go while busy is ignored.
- fill_done falling while in ADDR, CAPTURE or OUT aborts the scan (range was restarted and RAM contents are stale):
  - abort pulses 1 cycle; out_valid<=0; busy<=0; go to IDLE.
  - scan_done stays 0; max_count and max_index hold their partial values.
- idx has no wrap-around; it stops at RAM_WORDS-1.
- rd_addr holds its last value when not in ADDR.

Optional Feature:
- Macro RANGE_READER_SUM_EN.
- Defined: sum_count accumulates rd_data, zero-extended, in CAPTURE and is valid once scan_done=1. With the defaults it is 20 bits and cannot overflow.
- Undefined: no accumulator; sum_count is tied to 0.

Decomposition:
- Package range_pkg holds:
  - COUNT_W=16
  - the state enum (IDLE, WAIT_FILL, ADDR, CAPTURE, OUT, DONE)
  - RAM_WORDS/RAM_ADDR_BITS defaults, shared with range
- No sub-module. The max tracker and accumulator stay inline, since each is a few lines.

Test Plan:
- Behavioural RAM model (1-cycle latency) preloaded with Collatz step counts for n=1..16: 0,1,7,2,5,8,16,3,19,6,14,9,9,17,17,4. fill_done=1, scan_go pulse, out_ready=1 -> 16 words streamed in index order with matching counts; max_count=19, max_index=8; scan_done after 49 cycles; sum_count=137 with RANGE_READER_SUM_EN, 0 without.
- Same data, out_ready toggled on a pseudo-random pattern -> out_index/out_count stable while out_valid&&!out_ready; no word dropped or duplicated.
- scan_go with fill_done=0 for 10 cycles, then fill_done=1 -> busy=1 throughout; first rd_addr=0 the cycle after fill_done rises.
- All words=5 -> max_count=5, max_index=0 (tie keeps lowest index).
- Drop fill_done during word 6 -> abort pulses once; out_valid=0, busy=0, scan_done=0. A new scan_go after fill_done returns completes normally.
- Assert rst_n=0 mid-OUT -> all outputs 0 immediately (asynchronous); state IDLE; a rescan after release is correct.
